fios_result_collector: RTL and testbench

//   Receiving end of the RES_push path of the FIOS Montgomery multiplier. Captures the

---
 rtl/fios_pkg.sv | 15 +
 rtl/fios_res_bank.sv | 23 ++
 rtl/fios_result_collector.sv | 143 ++++++++++++++
 tb/tb_fios_result_collector.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fios_pkg.sv
// rtl/fios_pkg.sv - shared types, sizes and pointer-width helper for the FIOS result path
package fios_pkg;

  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} col_state_t;

  localparam int FIOS_S = 16;
  localparam int FIOS_W = 17;
  localparam int FIOS_N = FIOS_S + 1;

  // Width able to hold a word count 0..n inclusive
  function automatic int ptr_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fios_res_bank.sv
// rtl/fios_res_bank.sv - N x W result register file, one write port, one registered read port
module fios_res_bank #(
  parameter int N  = 17,
  parameter int W  = 17,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  // Write-first forwarding lets a frame closed on its only push be read on the same edge
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/fios_result_collector.sv
// rtl/fios_result_collector.sv - collects RES_push words per frame and streams them out LSW first
// FIOS_RES_DOUBLE_BUF_EN selects two ping-pong banks; default is a single bank.
module fios_result_collector
  import fios_pkg::*;
#(
  parameter int s = FIOS_S,
  parameter int W = FIOS_W
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         res_push_i,
  input  logic [W-1:0] res_word_i,
  input  logic         done_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [W-1:0] res_data_o,
  output logic         res_last_o,
  output logic         busy_o,
  output logic         overflow_o,
  output logic         len_err_o
);

  localparam int N  = s + 1;
  localparam int PW = ptr_width(N);
  localparam logic [PW-1:0] NW = PW'(N);
`ifdef FIOS_RES_DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  col_state_t    state;
  logic [PW-1:0] wr_ptr, rd_ptr, raddr, close_cnt, cnt_nb;
  logic          wr_bank, rd_bank, nb, nxt_wr, pend_next;
  logic          frame_ovf, acc, over_now, close, close_ok, fire;
  logic          full [NB];
  logic [PW-1:0] cnt  [NB];
  logic [W-1:0]  rdata [NB];

  assign over_now  = res_push_i && !full[wr_bank] && wr_ptr == NW;
  assign acc       = res_push_i && !full[wr_bank] && wr_ptr != NW;
  assign close     = done_i && !full[wr_bank];
  assign close_cnt = wr_ptr + PW'(acc);
  assign close_ok  = close && close_cnt != '0;
  assign fire      = res_valid_o && res_ready_i;
  assign cnt_nb    = full[nb] ? cnt[nb] : close_cnt;

`ifdef FIOS_RES_DOUBLE_BUF_EN
  assign nb        = ~rd_bank;
  assign nxt_wr    = ~wr_bank;
  assign pend_next = full[nb] || (close_ok && wr_bank == nb);
  assign busy_o    = full[0] & full[1];
`else
  assign nb        = 1'b0;
  assign nxt_wr    = 1'b0;
  assign pend_next = 1'b0;
  assign busy_o    = full[0];
`endif

  // Read address tracks the pointer value that will hold after this edge
  always_comb begin
    raddr = '0;
    if (state == DRAIN) begin
      raddr = rd_ptr;
      if (fire) raddr = res_last_o ? '0 : rd_ptr + 1'b1;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    fios_res_bank #(.N(N), .W(W), .AW(PW)) u_bank (
      .clk   (clock_i),
      .we    (acc && wr_bank == 1'(b)),
      .waddr (wr_ptr),
      .wdata (res_word_i),
      .raddr (raddr),
      .rdata (rdata[b])
    );
  end

  assign res_data_o = res_valid_o ? rdata[rd_bank] : '0;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= COLLECT;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      frame_ovf   <= 1'b0;
      res_valid_o <= 1'b0;
      res_last_o  <= 1'b0;
      overflow_o  <= 1'b0;
      len_err_o   <= 1'b0;
      for (int b = 0; b < NB; b++) begin
        full[b] <= 1'b0;
        cnt[b]  <= '0;
      end
    end else begin
      if (res_push_i && !acc) overflow_o <= 1'b1;
      if (over_now) frame_ovf <= 1'b1;
      if (acc) wr_ptr <= wr_ptr + 1'b1;
      // A frame that lost a word to overflow is also a length error
      if (close) begin
        wr_ptr    <= '0;
        frame_ovf <= 1'b0;
        if (close_cnt != NW || frame_ovf || over_now) len_err_o <= 1'b1;
        if (close_ok) begin
          full[wr_bank] <= 1'b1;
          cnt[wr_bank]  <= close_cnt;
          wr_bank       <= nxt_wr;
        end
      end
      case (state)
        COLLECT: if (close_ok) begin
          state       <= DRAIN;
          rd_bank     <= wr_bank;
          rd_ptr      <= '0;
          res_valid_o <= 1'b1;
          res_last_o  <= close_cnt == PW'(1);
        end
        DRAIN: if (fire) begin
          if (res_last_o) begin
            full[rd_bank] <= 1'b0;
            rd_ptr        <= '0;
            if (pend_next) begin
              rd_bank    <= nb;
              res_last_o <= cnt_nb == PW'(1);
            end else begin
              state       <= COLLECT;
              res_valid_o <= 1'b0;
              res_last_o  <= 1'b0;
            end
          end else begin
            rd_ptr     <= rd_ptr + 1'b1;
            res_last_o <= rd_ptr + PW'(2) == cnt[rd_bank];
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fios_result_collector.sv
// tb/tb_fios_result_collector.sv - table-driven and scoreboard bench for fios_result_collector (s=4)
module tb_fios_result_collector;

  localparam int S = 4;
  localparam int W = 17;
  localparam int N = S + 1;

  logic         clock_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         res_push_i = 1'b0;
  logic [W-1:0] res_word_i = '0;
  logic         done_i = 1'b0;
  logic         res_ready_i = 1'b0;
  logic         res_valid_o, res_last_o, busy_o, overflow_o, len_err_o;
  logic [W-1:0] res_data_o;

  always #5 clock_i = ~clock_i;

  fios_result_collector #(.s(S), .W(W)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .res_push_i  (res_push_i),
    .res_word_i  (res_word_i),
    .done_i      (done_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .res_last_o  (res_last_o),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .len_err_o   (len_err_o)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  typedef struct {
    int np;
    bit done_push;
    int pat;
    bit ovf;
    bit len;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pop on each handshake, and hold check while stalled
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge clock_i) begin
    exp_t e;
    if (reset_i) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(res_valid_o), 32'd1);
        chk("hold_data", 32'(res_data_o), 32'(prev_data));
      end
      if (res_valid_o && res_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(res_data_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 32'(res_data_o), 32'(e.data));
          chk("word_last", 32'(res_last_o), 32'(e.last));
        end
      end
      prev_hold = res_valid_o && !res_ready_i;
      prev_data = res_data_o;
    end
  end

  task automatic do_reset();
    reset_i = 1'b1; res_push_i = 1'b0; done_i = 1'b0; res_ready_i = 1'b0;
    repeat (2) begin @(posedge clock_i); #1; end
    reset_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_word(input logic [W-1:0] w, input bit d, input bit keep, input bit lst);
    exp_t e;
    res_push_i = 1'b1; res_word_i = w; done_i = d;
    if (keep) begin
      e.data = w; e.last = lst;
      exp_q.push_back(e);
    end
    @(posedge clock_i); #1;
    res_push_i = 1'b0; done_i = 1'b0;
  endtask

  task automatic drain(input int pat, input int exp_cycles);
    int c = 0;
    while (exp_q.size() != 0 && c < 60) begin
      res_ready_i = (pat == 0) || (c % 2 == 0);
      @(posedge clock_i); #1;
      c++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_cycles", 32'(c), 32'(exp_cycles));
    chk("valid_after_last", 32'(res_valid_o), 32'd0);
    res_ready_i = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{np: 5, done_push: 1, pat: 0, ovf: 0, len: 0};
    vecs[1] = '{np: 5, done_push: 1, pat: 1, ovf: 0, len: 0};
    vecs[2] = '{np: 6, done_push: 1, pat: 0, ovf: 1, len: 1};
    vecs[3] = '{np: 3, done_push: 0, pat: 0, ovf: 0, len: 1};
    vecs[4] = '{np: 1, done_push: 1, pat: 0, ovf: 0, len: 1};
    vecs[5] = '{np: 5, done_push: 0, pat: 1, ovf: 0, len: 0};
    vecs[6] = '{np: 6, done_push: 0, pat: 1, ovf: 1, len: 1};

    do_reset();
    chk("rst_valid", 32'(res_valid_o), 32'd0);
    chk("rst_last", 32'(res_last_o), 32'd0);
    chk("rst_data", 32'(res_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_len", 32'(len_err_o), 32'd0);

    for (int v = 0; v < 7; v++) begin
      int cap;
      do_reset();
      cap = (vecs[v].np < N) ? vecs[v].np : N;
      for (int i = 0; i < vecs[v].np; i++) begin
        if (i == vecs[v].np - 1 && vecs[v].done_push) chk("valid_before_done", 32'(res_valid_o), 32'd0);
        push_word(W'(i + 1), vecs[v].done_push && i == vecs[v].np - 1, i < N, i + 1 == cap);
      end
      if (!vecs[v].done_push) begin
        chk("valid_before_done", 32'(res_valid_o), 32'd0);
        done_i = 1'b1;
        @(posedge clock_i); #1;
        done_i = 1'b0;
      end
      chk("valid_latency", 32'(res_valid_o), 32'd1);
      drain(vecs[v].pat, vecs[v].pat == 0 ? cap : 2 * cap - 1);
      chk("vec_ovf", 32'(overflow_o), 32'(vecs[v].ovf));
      chk("vec_len", 32'(len_err_o), 32'(vecs[v].len));
    end

    // Push while frame 1 is draining and the consumer is stalled
    do_reset();
    for (int i = 0; i < N; i++) push_word(W'(i + 1), i == N - 1, 1, i == N - 1);
`ifdef FIOS_RES_DOUBLE_BUF_EN
    chk("db_busy_one_full", 32'(busy_o), 32'd0);
    for (int i = 0; i < N; i++) push_word(W'(17'h11 + i), i == N - 1, 1, i == N - 1);
    chk("db_busy_both_full", 32'(busy_o), 32'd1);
    chk("db_ovf", 32'(overflow_o), 32'd0);
    drain(0, 2 * N);
    chk("db_busy_end", 32'(busy_o), 32'd0);
`else
    chk("sb_busy", 32'(busy_o), 32'd1);
    push_word(17'h100, 0, 0, 0);
    chk("sb_ovf", 32'(overflow_o), 32'd1);
    chk("sb_busy_after", 32'(busy_o), 32'd1);
    drain(0, N);
    chk("sb_busy_end", 32'(busy_o), 32'd0);
`endif

    // Reset with word 3 on the output aborts the frame and clears sticky flags
    do_reset();
    for (int i = 0; i < N + 1; i++) push_word(W'(i + 1), i == N, i < N, i == N - 1);
    res_ready_i = 1'b1;
    repeat (2) begin @(posedge clock_i); #1; end
    chk("pre_rst_ovf", 32'(overflow_o), 32'd1);
    chk("pre_rst_word3", 32'(res_data_o), 32'd3);
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    chk("mid_rst_valid", 32'(res_valid_o), 32'd0);
    chk("mid_rst_ovf", 32'(overflow_o), 32'd0);
    chk("mid_rst_len", 32'(len_err_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    exp_q.delete();
    res_ready_i = 1'b0;
    for (int i = 0; i < N; i++) push_word(W'(17'h21 + i), i == N - 1, 1, i == N - 1);
    chk("post_rst_latency", 32'(res_valid_o), 32'd1);
    drain(0, N);
    chk("post_rst_len", 32'(len_err_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
